// File: rtl/ddr_dummy_responder.sv
// Behavioural single-word memory responder standing in for the DDR2 controller.
// Accepts one command at a time and answers after a fixed read/write latency.
// Data lives in a small fully associative table that allocates FIFO-style.
// Initiator handshake violations and read misses are flagged as sticky flags.
module ddr_dummy_responder #(
   parameter int unsigned RD_LATENCY = 3,
   parameter int unsigned WR_LATENCY = 2,
   parameter int unsigned DEPTH      = 16,
   parameter logic [31:0] MISS_DATA  = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] mem_data_wr1,
   output logic [31:0] mem_data_rd1,
   input  logic [27:0] mem_data_addr1,
   input  logic        mem_rw_data1,
   input  logic        mem_valid_data1,
   output logic        mem_ready_data1,
   output logic        proto_err,
   output logic        rd_miss
);

   localparam int unsigned MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
   // The counter holds LAT-1, so it never needs to represent MAX_LAT itself
   localparam int unsigned CW      = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam int unsigned PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP,
      GAP
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [27:0]       addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic              rw_q, rw_d;
   logic              ready_q, ready_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              proto_q, proto_d;
   logic              miss_q, miss_d;
   logic [PW-1:0]     ptr_q, ptr_d;
   logic [DEPTH-1:0]  vld_q, vld_d;
   logic [27:0]       tag_q  [DEPTH];
   logic [27:0]       tag_d  [DEPTH];
   logic [31:0]       data_q [DEPTH];
   logic [31:0]       data_d [DEPTH];

   logic              hit;
   logic [PW-1:0]     hit_idx;
   logic              go_resp;

   // Associative lookup of the captured address across all valid entries
   always_comb begin
      hit     = 1'b0;
      hit_idx = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (vld_q[i] && (tag_q[i] == addr_q)) begin
            hit     = 1'b1;
            hit_idx = PW'(i);
         end
      end
   end

   // Next-state, command execution and flag logic
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rw_d    = rw_q;
      ready_d = 1'b0;
      rdata_d = rdata_q;
      proto_d = proto_q;
      miss_d  = miss_q;
      ptr_d   = ptr_q;
      vld_d   = vld_q;
      tag_d   = tag_q;
      data_d  = data_q;
      go_resp = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_valid_data1) begin
               addr_d  = mem_data_addr1;
               wdata_d = mem_data_wr1;
               rw_d    = mem_rw_data1;
               cnt_d   = mem_rw_data1 ? CW'(WR_LATENCY - 1) : CW'(RD_LATENCY - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               go_resp = 1'b1;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         RESP:    state_d = GAP;
         GAP:     state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Initiator must hold the command unchanged until the response cycle ends
      if (((state_q == BUSY) || (state_q == RESP)) &&
          (!mem_valid_data1 || (mem_data_addr1 != addr_q) ||
           (mem_rw_data1 != rw_q) || (mem_data_wr1 != wdata_q))) begin
         proto_d = 1'b1;
      end

      // The captured command takes effect on the edge that enters RESP
      if (go_resp) begin
         ready_d = 1'b1;
         if (rw_q) begin
            if (hit) begin
               data_d[hit_idx] = wdata_q;
            end else begin
               tag_d[ptr_q]  = addr_q;
               data_d[ptr_q] = wdata_q;
               vld_d[ptr_q]  = 1'b1;
               ptr_d         = (ptr_q == PTR_LAST) ? '0 : ptr_q + PW'(1);
            end
         end else begin
            if (hit) begin
               rdata_d = data_q[hit_idx];
            end else begin
               rdata_d = MISS_DATA;
               miss_d  = 1'b1;
            end
         end
      end
   end

   // Control state, outputs and entry valid bits
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rw_q    <= 1'b0;
         ready_q <= 1'b0;
         rdata_q <= '0;
         proto_q <= 1'b0;
         miss_q  <= 1'b0;
         ptr_q   <= '0;
         vld_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rw_q    <= rw_d;
         ready_q <= ready_d;
         rdata_q <= rdata_d;
         proto_q <= proto_d;
         miss_q  <= miss_d;
         ptr_q   <= ptr_d;
         vld_q   <= vld_d;
      end
   end

   // Table storage; contents are qualified by vld_q so no reset is needed
   always_ff @(posedge clk) begin
      tag_q  <= tag_d;
      data_q <= data_d;
   end

   assign mem_data_rd1    = rdata_q;
   assign mem_ready_data1 = ready_q;
   assign proto_err       = proto_q;
   assign rd_miss         = miss_q;

endmodule

// File: tb/tb_ddr_dummy_responder.sv
// Randomised self-checking bench for ddr_dummy_responder against a map/FIFO model.
module tb_ddr_dummy_responder;

   localparam int unsigned DEPTH = 16;
   localparam int RD_LAT = 3;
   localparam int WR_LAT = 2;
   localparam logic [31:0] MISS = 32'hDEADBEEF;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] wr;
   logic [31:0] rd;
   logic [27:0] addr;
   logic        rw;
   logic        valid;
   logic        ready;
   logic        proto_err;
   logic        rd_miss;

   int checks   = 0;
   int failures = 0;

   // Reference model: address->data map, allocation order queue, sticky miss
   logic [31:0] mdl_mem [logic [27:0]];
   logic [27:0] mdl_order [$];
   bit          mdl_miss;

   always #5 clk = ~clk;

   ddr_dummy_responder #(
      .RD_LATENCY(RD_LAT),
      .WR_LATENCY(WR_LAT),
      .DEPTH(DEPTH),
      .MISS_DATA(MISS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .mem_data_wr1(wr),
      .mem_data_rd1(rd),
      .mem_data_addr1(addr),
      .mem_rw_data1(rw),
      .mem_valid_data1(valid),
      .mem_ready_data1(ready),
      .proto_err(proto_err),
      .rd_miss(rd_miss)
   );

   function automatic void mdl_write(input logic [27:0] a, input logic [31:0] d);
      logic [27:0] old;
      if (mdl_mem.exists(a)) begin
         mdl_mem[a] = d;
      end else begin
         if (mdl_order.size() == DEPTH) begin
            old = mdl_order.pop_front();
            mdl_mem.delete(old);
         end
         mdl_order.push_back(a);
         mdl_mem[a] = d;
      end
   endfunction

   function automatic logic [31:0] mdl_read(input logic [27:0] a);
      if (mdl_mem.exists(a)) return mdl_mem[a];
      mdl_miss = 1'b1;
      return MISS;
   endfunction

   function automatic void mdl_clear();
      mdl_mem.delete();
      mdl_order.delete();
      mdl_miss = 1'b0;
   endfunction

   // Drive one well-behaved command; report latency (edges after accept),
   // read data seen in the ready cycle and number of ready pulses observed.
   task automatic xact(input bit w, input logic [27:0] a, input logic [31:0] d,
                       output logic [31:0] r, output int lat, output int pulses);
      @(posedge clk); #1;
      valid = 1'b1; rw = w; addr = a; wr = d;
      lat = -1; pulses = 0; r = '0;
      for (int n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (ready) begin
            lat = n - 1; r = rd; pulses = 1;
            break;
         end
      end
      @(posedge clk); #1;
      valid = 1'b0;
      if (ready) pulses++;
   endtask

   task automatic test_reset();
      rst = 1'b0; valid = 1'b0; rw = 1'b0; addr = '0; wr = '0;
      mdl_clear();
      #12;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", ready); end
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 00000000", rd); end
      checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL reset_proto: got %b expected 0", proto_err); end
      checks++; if (rd_miss !== 1'b0) begin failures++; $display("FAIL reset_miss: got %b expected 0", rd_miss); end
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   task automatic test_basic();
      logic [31:0] r, e; int lat, p;
      xact(1'b1, 28'h0000008, 32'h010000FF, r, lat, p);
      mdl_write(28'h0000008, 32'h010000FF);
      checks++; if (lat !== WR_LAT) begin failures++; $display("FAIL basic_wr_lat: got %0d expected %0d", lat, WR_LAT); end
      checks++; if (p !== 1) begin failures++; $display("FAIL basic_wr_pulses: got %0d expected 1", p); end
      xact(1'b0, 28'h0000008, '0, r, lat, p);
      e = mdl_read(28'h0000008);
      checks++; if (lat !== RD_LAT) begin failures++; $display("FAIL basic_rd_lat: got %0d expected %0d", lat, RD_LAT); end
      checks++; if (r !== e) begin failures++; $display("FAIL basic_rd_data: got %h expected %h", r, e); end
      checks++; if (rd_miss !== mdl_miss) begin failures++; $display("FAIL basic_rd_miss: got %b expected %b", rd_miss, mdl_miss); end
   endtask

   task automatic test_full_compare();
      logic [31:0] r, e; int lat, p;
      xact(1'b1, 28'h1000008, 32'h000AAAAA, r, lat, p);
      mdl_write(28'h1000008, 32'h000AAAAA);
      xact(1'b0, 28'h0000008, '0, r, lat, p);
      e = mdl_read(28'h0000008);
      checks++; if (r !== e) begin failures++; $display("FAIL tag_low: got %h expected %h", r, e); end
      xact(1'b0, 28'h1000008, '0, r, lat, p);
      e = mdl_read(28'h1000008);
      checks++; if (r !== e) begin failures++; $display("FAIL tag_high: got %h expected %h", r, e); end
      checks++; if (rd_miss !== 1'b0) begin failures++; $display("FAIL tag_nomiss: got %b expected 0", rd_miss); end
   endtask

   task automatic test_miss();
      logic [31:0] r, e; int lat, p;
      xact(1'b0, 28'h2300030, '0, r, lat, p);
      e = mdl_read(28'h2300030);
      checks++; if (r !== e) begin failures++; $display("FAIL miss_data: got %h expected %h", r, e); end
      checks++; if (rd_miss !== 1'b1) begin failures++; $display("FAIL miss_flag: got %b expected 1", rd_miss); end
      xact(1'b0, 28'h0000008, '0, r, lat, p);
      e = mdl_read(28'h0000008);
      checks++; if (r !== e) begin failures++; $display("FAIL miss_then_hit: got %h expected %h", r, e); end
      checks++; if (rd_miss !== 1'b1) begin failures++; $display("FAIL miss_sticky: got %b expected 1", rd_miss); end
      // A write must leave the last read data on the bus
      xact(1'b1, 28'h0000010, 32'h12345678, r, lat, p);
      mdl_write(28'h0000010, 32'h12345678);
      checks++; if (rd !== e) begin failures++; $display("FAIL rdata_hold_on_write: got %h expected %h", rd, e); end
   endtask

   task automatic test_evict();
      logic [31:0] r, e; int lat, p;
      logic [27:0] a;
      for (int i = 0; i <= 16; i++) begin
         a = 28'h4000000 + 28'(i * 16);
         e = $urandom;
         xact(1'b1, a, e, r, lat, p);
         mdl_write(a, e);
         checks++; if (lat !== WR_LAT) begin failures++; $display("FAIL evict_wr_lat[%0d]: got %0d expected %0d", i, lat, WR_LAT); end
      end
      xact(1'b0, 28'h4000000, '0, r, lat, p);
      e = mdl_read(28'h4000000);
      checks++; if (r !== MISS || r !== e) begin failures++; $display("FAIL evict_a0: got %h expected %h", r, MISS); end
      for (int i = 1; i <= 16; i++) begin
         a = 28'h4000000 + 28'(i * 16);
         xact(1'b0, a, '0, r, lat, p);
         e = mdl_read(a);
         checks++; if (r !== e) begin failures++; $display("FAIL evict_hit[%0d]: got %h expected %h", i, r, e); end
      end
      xact(1'b1, 28'h4000050, 32'hA5A5_0005, r, lat, p);
      mdl_write(28'h4000050, 32'hA5A5_0005);
      xact(1'b0, 28'h4000010, '0, r, lat, p);
      e = mdl_read(28'h4000010);
      checks++; if (r !== e) begin failures++; $display("FAIL rewrite_keeps_a1: got %h expected %h", r, e); end
      xact(1'b0, 28'h4000050, '0, r, lat, p);
      e = mdl_read(28'h4000050);
      checks++; if (r !== e) begin failures++; $display("FAIL rewrite_a5: got %h expected %h", r, e); end
   endtask

   task automatic test_random();
      logic [31:0] r, e, d; int lat, p;
      logic [27:0] pool [24];
      logic [27:0] a;
      logic [20:0] base;
      bit w;
      base = 21'($urandom);
      for (int i = 0; i < 24; i++) pool[i] = {4'(i / 8), base, 3'(i % 8)};
      for (int k = 0; k < 80; k++) begin
         a = ($urandom_range(0, 4) == 0) ? 28'($urandom) : pool[$urandom_range(0, 23)];
         w = 1'($urandom);
         d = $urandom;
         xact(w, a, d, r, lat, p);
         checks++; if (lat !== (w ? WR_LAT : RD_LAT)) begin failures++; $display("FAIL rand_lat[%0d]: got %0d expected %0d", k, lat, w ? WR_LAT : RD_LAT); end
         checks++; if (p !== 1) begin failures++; $display("FAIL rand_pulses[%0d]: got %0d expected 1", k, p); end
         if (w) begin
            mdl_write(a, d);
         end else begin
            e = mdl_read(a);
            checks++; if (r !== e) begin failures++; $display("FAIL rand_rdata[%0d] @%h: got %h expected %h", k, a, r, e); end
         end
         checks++; if (rd_miss !== mdl_miss) begin failures++; $display("FAIL rand_miss[%0d]: got %b expected %b", k, rd_miss, mdl_miss); end
      end
      checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rand_proto_clean: got %b expected 0", proto_err); end
   endtask

   task automatic test_proto();
      logic [31:0] r, e; int lat, p, n;
      // Address changed while BUSY: captured write must still execute
      @(posedge clk); #1;
      valid = 1'b1; rw = 1'b1; addr = 28'h5555550; wr = 32'hC0DE_0001;
      @(posedge clk); #1;
      addr = 28'h5555554;
      lat = -1; p = 0;
      for (n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (ready) begin lat = n; p = 1; break; end
      end
      @(posedge clk); #1;
      valid = 1'b0;
      if (ready) p++;
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (ready) p++; end
      mdl_write(28'h5555550, 32'hC0DE_0001);
      checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_addr_flag: got %b expected 1", proto_err); end
      checks++; if (p !== 1) begin failures++; $display("FAIL proto_addr_pulses: got %0d expected 1", p); end
      checks++; if (lat !== WR_LAT) begin failures++; $display("FAIL proto_addr_lat: got %0d expected %0d", lat, WR_LAT); end
      xact(1'b0, 28'h5555550, '0, r, lat, p);
      e = mdl_read(28'h5555550);
      checks++; if (r !== e) begin failures++; $display("FAIL proto_captured: got %h expected %h", r, e); end
      xact(1'b0, 28'h5555554, '0, r, lat, p);
      e = mdl_read(28'h5555554);
      checks++; if (r !== e) begin failures++; $display("FAIL proto_changed_addr: got %h expected %h", r, e); end
      // Valid dropped while BUSY: captured read still answers once
      @(posedge clk); #1;
      valid = 1'b1; rw = 1'b0; addr = 28'h5555550; wr = '0;
      @(posedge clk); #1;
      valid = 1'b0;
      lat = -1; p = 0; r = '0;
      for (n = 1; n <= 8; n++) begin
         @(posedge clk); #1;
         if (ready) begin
            if (p == 0) begin lat = n; r = rd; end
            p++;
         end
      end
      e = mdl_read(28'h5555550);
      checks++; if (p !== 1) begin failures++; $display("FAIL proto_drop_pulses: got %0d expected 1", p); end
      checks++; if (lat !== RD_LAT) begin failures++; $display("FAIL proto_drop_lat: got %0d expected %0d", lat, RD_LAT); end
      checks++; if (r !== e) begin failures++; $display("FAIL proto_drop_data: got %h expected %h", r, e); end
      checks++; if (proto_err !== 1'b1) begin failures++; $display("FAIL proto_sticky: got %b expected 1", proto_err); end
   endtask

   task automatic test_hold_valid();
      logic [31:0] r, e; int lat, p, bad, exp_p;
      bit exp;
      // With valid held, each command is ready LAT edges after accept and
      // the next accept comes three edges after ready (RESP, GAP, IDLE).
      @(posedge clk); #1;
      valid = 1'b1; rw = 1'b1; addr = 28'h6000000; wr = 32'h0BAD_F00D;
      bad = 0; p = 0; exp_p = 0;
      for (int k = 0; k <= 8; k++) begin
         @(posedge clk); #1;
         exp = (k >= WR_LAT) && (((k - WR_LAT) % (WR_LAT + 3)) == 0);
         if (exp) exp_p++;
         if (ready) p++;
         if (ready !== exp) bad++;
      end
      valid = 1'b0;
      mdl_write(28'h6000000, 32'h0BAD_F00D);
      checks++; if (bad !== 0) begin failures++; $display("FAIL hold_ready_pattern: got %0d wrong cycles expected 0", bad); end
      checks++; if (p !== exp_p) begin failures++; $display("FAIL hold_pulses: got %0d expected %0d", p, exp_p); end
      xact(1'b0, 28'h6000000, '0, r, lat, p);
      e = mdl_read(28'h6000000);
      checks++; if (r !== e) begin failures++; $display("FAIL hold_data: got %h expected %h", r, e); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] r, e; int lat, p;
      xact(1'b1, 28'h7000000, 32'h7777_0000, r, lat, p);
      mdl_write(28'h7000000, 32'h7777_0000);
      @(posedge clk); #1;
      valid = 1'b1; rw = 1'b0; addr = 28'h7000000;
      @(posedge clk); #1;
      rst = 1'b0; valid = 1'b0;
      mdl_clear();
      p = 0;
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (ready) p++; end
      checks++; if (p !== 0) begin failures++; $display("FAIL rstmid_ready: got %0d pulses expected 0", p); end
      checks++; if (proto_err !== 1'b0) begin failures++; $display("FAIL rstmid_proto: got %b expected 0", proto_err); end
      checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_rdata: got %h expected 00000000", rd); end
      rst = 1'b1;
      p = 0;
      for (int i = 0; i < 4; i++) begin @(posedge clk); #1; if (ready) p++; end
      checks++; if (p !== 0) begin failures++; $display("FAIL rstmid_no_late_ready: got %0d pulses expected 0", p); end
      xact(1'b0, 28'h7000000, '0, r, lat, p);
      e = mdl_read(28'h7000000);
      checks++; if (r !== e) begin failures++; $display("FAIL rstmid_empty: got %h expected %h", r, e); end
      checks++; if (rd_miss !== mdl_miss) begin failures++; $display("FAIL rstmid_miss: got %b expected %b", rd_miss, mdl_miss); end
      checks++; if (lat !== RD_LAT) begin failures++; $display("FAIL rstmid_lat: got %0d expected %0d", lat, RD_LAT); end
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_full_compare();
      test_miss();
      test_evict();
      test_random();
      test_proto();
      test_hold_valid();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
